mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters.
- Port 0 is the core (fetch and load/store); port 1 is the external loader/debug port.
- Grants at most one access per cycle and steers the memory address, write data and write enable.
- Routes synchronous read data back to the port that issued the read, after the memory's read latency, using a per-cycle owner pipeline.
- Supports round-robin sharing plus an external-port lock, so the loader can hold memory while the core stalls.

Parameters:
ADDR_WIDTH, 32, address width of all ports.
DATA_WIDTH, 32, data width of all ports.
READ_LATENCY, 1, cycles from a granted read to mem_rd valid; legal range 1..4.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
core_req  input  1  core requests an access this cycle.
core_we  input  1  1 = write, 0 = read.
core_addr  input  ADDR_WIDTH  core access address.
core_wdata  input  DATA_WIDTH  core write data.
core_gnt  output  1  core access accepted this cycle (combinational).
core_rvalid  output  1  core read data valid.
core_rdata  output  DATA_WIDTH  core read data.
ext_req  input  1  external port requests an access.
ext_we  input  1  1 = write, 0 = read.
ext_addr  input  ADDR_WIDTH  external access address.
ext_wdata  input  DATA_WIDTH  external write data.
ext_lock  input  1  external port requests exclusive ownership.
ext_gnt  output  1  external access accepted this cycle (combinational).
ext_rvalid  output  1  external read data valid.
ext_rdata  output  DATA_WIDTH  external read data.
mem_a  output  ADDR_WIDTH  memory address.
mem_wd  output  DATA_WIDTH  memory write data.
mem_we  output  1  memory write enable.
mem_rd  input  DATA_WIDTH  memory read data; valid READ_LATENCY cycles after the address.
locked  output  1  external lock currently held.

Behaviour:
- Reset (asynchronous, active-high): last_grant=1, so the core wins the first contention. Lock register cleared. Owner/valid pipeline cleared.
- During and immediately after reset: locked=0, core_rvalid=0, ext_rvalid=0. No rvalid is ever produced for a read issued before reset, including a reset asserted mid-latency.
- Grant is combinational from req, lock and last_grant. Exactly one of core_gnt and ext_gnt is high, or neither.
- Lock held (locked=1):
  - core_gnt=0.
  - ext_gnt=ext_req.
- No lock, single requester: that requester is granted.
- No lock, both requesting: grant goes to the port not equal to last_grant (round-robin).
- last_grant updates to the granted port on each grant. It holds when nothing is granted.
- Memory outputs:
  - mem_a and mem_wd take the granted port's values; with no grant they take the core's values.
  - mem_we = granted & granted port's we; mem_we=0 with no grant.
- Write timing: a write completes in its grant cycle. It produces no rvalid.
- Read timing:
  - A granted read enters {valid=1, owner} into a READ_LATENCY-deep shift pipeline.
  - At the pipeline tail, the owner's rvalid pulses for one cycle, with rdata=mem_rd.
  - The non-owner's rvalid=0.
  - rdata of both ports is driven from mem_rd at all times and is only meaningful when the matching rvalid is high.
- Back-to-back grants are allowed every cycle. Reads from alternating ports return in issue order without loss.
- Lock state machine:
  - UNLOCKED -> LOCKED at a clock edge where ext_gnt=1 and ext_lock=1.
  - LOCKED -> UNLOCKED at any edge where ext_lock=0. Release does not require ext_req.
  - In LOCKED with ext_req=0, memory is idle: mem_we=0, no grants.
  - A core request arriving in LOCKED waits; it is granted in the first cycle after release.
- Lock release and ext_req high in the same cycle: that cycle still follows LOCKED rules (ext granted, core not). Normal arbitration resumes next cycle.
- Reads issued before the lock returns normally while LOCKED. The owner pipeline is independent of lock state.
- Requesters hold req, we, addr and wdata stable until gnt. A dropped request is simply not served.

Test Plan:
- Reset mid-read: READ_LATENCY=2, core read addr 0x10 granted, reset asserted next cycle -> no core_rvalid ever; locked=0; core_gnt=1 again after reset release.
- Single port: core read 0x0 with mem holding 0x00500093 -> core_gnt same cycle; core_rvalid=1, core_rdata=0x00500093 after 1 cycle; ext_rvalid=0.
- Contention: both request reads every cycle for 4 cycles from reset -> grants core, ext, core, ext; rvalids return to matching owners, one cycle later, in the same order.
- Write: ext write addr 0x20 data 0xDEADBEEF -> ext_gnt=1, mem_we=1, mem_a=0x20, mem_wd=0xDEADBEEF in the same cycle; no rvalid. A following core read of 0x20 returns 0xDEADBEEF.
- Lock: ext request with ext_lock=1 at cycle 0 -> locked=1 from cycle 1; core_req held high gets core_gnt=0 for 5 cycles. ext_lock dropped at cycle 5 -> locked=0 at cycle 6 and core_gnt=1 at cycle 6.
- Latency sweep: READ_LATENCY=4, alternating core/ext reads every cycle for 8 cycles -> 8 rvalid pulses, each 4 cycles after its grant, each routed to the correct port.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Requester and memory bus bundle for the two-port memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  core_req;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_gnt;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic                  ext_req;
  logic                  ext_we;
  logic [ADDR_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_wdata;
  logic                  ext_lock;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [DATA_WIDTH-1:0] ext_rdata;

  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  locked;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    input  mem_rd,
    output core_gnt, core_rvalid, core_rdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_a, mem_wd, mem_we, locked
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    output mem_rd,
    input  core_gnt, core_rvalid, core_rdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_a, mem_wd, mem_we, locked
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter with external lock sharing one synchronous
//             memory between the core and the external loader port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input wire            clk,
  input wire            reset,
  mem_arbiter_if.slave  bus
);

  localparam logic c_PORT_CORE = 1'b0;
  localparam logic c_PORT_EXT  = 1'b1;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("mem_arbiter: READ_LATENCY must be in 1..4");
  end

  lock_state_t               r_state;
  logic                      r_last_grant;
  logic [READ_LATENCY-1:0]   r_vld;
  logic [READ_LATENCY-1:0]   r_own;

  logic                      w_core_gnt;
  logic                      w_ext_gnt;
  logic                      w_any_gnt;
  logic                      w_rd_issue;
  logic [ADDR_WIDTH-1:0]     w_mem_a;
  logic [DATA_WIDTH-1:0]     w_mem_wd;

  // While locked the core is shut out entirely; otherwise contention goes
  // to whichever port did not win last time.
  always_comb begin
    w_core_gnt = 1'b0;
    w_ext_gnt  = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_ext_gnt = bus.ext_req;
    end else if (bus.core_req && bus.ext_req) begin
      if (r_last_grant == c_PORT_EXT) begin
        w_core_gnt = 1'b1;
      end else begin
        w_ext_gnt = 1'b1;
      end
    end else begin
      w_core_gnt = bus.core_req;
      w_ext_gnt  = bus.ext_req;
    end
  end

  assign w_any_gnt  = w_core_gnt | w_ext_gnt;
  assign w_rd_issue = (w_core_gnt & ~bus.core_we) | (w_ext_gnt & ~bus.ext_we);
  assign w_mem_a    = w_ext_gnt ? bus.ext_addr  : bus.core_addr;
  assign w_mem_wd   = w_ext_gnt ? bus.ext_wdata : bus.core_wdata;

  assign bus.core_gnt = w_core_gnt;
  assign bus.ext_gnt  = w_ext_gnt;
  assign bus.mem_a    = w_mem_a;
  assign bus.mem_wd   = w_mem_wd;
  assign bus.mem_we   = (w_core_gnt & bus.core_we) | (w_ext_gnt & bus.ext_we);
  assign bus.locked   = (r_state == ST_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_UNLOCKED;
      r_last_grant <= c_PORT_EXT;
    end else begin
      if (w_any_gnt) begin
        r_last_grant <= w_ext_gnt;
      end
      case (r_state)
        ST_UNLOCKED: if (w_ext_gnt && bus.ext_lock) r_state <= ST_LOCKED;
        ST_LOCKED:   if (!bus.ext_lock)             r_state <= ST_UNLOCKED;
      endcase
    end
  end

  // Owner pipeline mirrors the memory's read latency so each returning word
  // is steered to the port that issued it, independent of lock state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= w_rd_issue;
      r_own[0] <= w_ext_gnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_own[i] <= r_own[i-1];
      end
    end
  end

  assign bus.core_rvalid = r_vld[READ_LATENCY-1] & ~r_own[READ_LATENCY-1];
  assign bus.ext_rvalid  = r_vld[READ_LATENCY-1] &  r_own[READ_LATENCY-1];
  assign bus.core_rdata  = bus.mem_rd;
  assign bus.ext_rdata   = bus.mem_rd;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Drives three arbiters (latency 1, 2, 4) with shared stimulus and
//             compares them against a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          core_req, core_we, ext_req, ext_we, ext_lock;
  logic [AW-1:0] core_addr, ext_addr;
  logic [DW-1:0] core_wdata, ext_wdata;

  logic          cg_a [NI];
  logic          eg_a [NI];
  logic          we_a [NI];
  logic          lk_a [NI];
  logic          crv_a[NI];
  logic          erv_a[NI];
  logic [AW-1:0] a_a  [NI];
  logic [DW-1:0] wd_a [NI];
  logic [DW-1:0] crd_a[NI];
  logic [DW-1:0] erd_a[NI];

  logic [DW-1:0] dp [4];
  logic [DW-1:0] env_val [256];
  logic          env_wr  [256];
  logic          env_clr;
  logic [7:0]    env_idx;

  function automatic logic [31:0] init_val(int a);
    return (a == 0) ? 32'h0050_0093 : 32'h1000_0000 + a * 32'h0001_0203;
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_if ();
    assign u_if.core_req   = core_req;
    assign u_if.core_we    = core_we;
    assign u_if.core_addr  = core_addr;
    assign u_if.core_wdata = core_wdata;
    assign u_if.ext_req    = ext_req;
    assign u_if.ext_we     = ext_we;
    assign u_if.ext_addr   = ext_addr;
    assign u_if.ext_wdata  = ext_wdata;
    assign u_if.ext_lock   = ext_lock;
    assign u_if.mem_rd     = dp[L-1];
    assign cg_a[k]  = u_if.core_gnt;
    assign eg_a[k]  = u_if.ext_gnt;
    assign we_a[k]  = u_if.mem_we;
    assign lk_a[k]  = u_if.locked;
    assign crv_a[k] = u_if.core_rvalid;
    assign erv_a[k] = u_if.ext_rvalid;
    assign a_a[k]   = u_if.mem_a;
    assign wd_a[k]  = u_if.mem_wd;
    assign crd_a[k] = u_if.core_rdata;
    assign erd_a[k] = u_if.ext_rdata;
    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(L)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
    );
  end

  // Synchronous memory behind the arbiter, followed by a 4-deep data pipe.
  assign env_idx = a_a[0][7:0];
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 256; i++) env_wr[i] <= 1'b0;
    end else if (we_a[0]) begin
      env_wr[env_idx]  <= 1'b1;
      env_val[env_idx] <= wd_a[0];
    end
    dp[0] <= env_wr[env_idx] ? env_val[env_idx] : init_val(int'(env_idx));
    for (int i = 1; i < 4; i++) dp[i] <= dp[i-1];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          issue;
    logic        owner;
    logic [31:0] data;
  } rd_t;

  rd_t         q[$];
  logic        m_last, m_locked, rst_pulse;
  logic        sh_wr [256];
  logic [31:0] sh_val[256];
  int          cyc, checks, errors, cnt_crv4, cnt_erv4;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (L=%0d) cyc=%0d actual=%h expected=%h", nm, lat_of(k), cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic ecg, eeg, ewe, hit, own;
    logic [31:0] ea, ewd, dat;
    int lat;
    if (reset || rst_pulse) begin
      q.delete();
      m_last   = 1'b1;
      m_locked = 1'b0;
    end
    ecg = 1'b0;
    eeg = 1'b0;
    if (m_locked) eeg = ext_req;
    else if (core_req && ext_req) begin
      ecg = m_last;
      eeg = !m_last;
    end else begin
      ecg = core_req;
      eeg = ext_req;
    end
    ewe = (ecg && core_we) || (eeg && ext_we);
    ea  = eeg ? ext_addr : core_addr;
    ewd = eeg ? ext_wdata : core_wdata;
    for (int k = 0; k < NI; k++) begin
      lat = lat_of(k);
      hit = 1'b0;
      own = 1'b0;
      dat = '0;
      foreach (q[j]) if (q[j].issue + lat == cyc) begin
        hit = 1'b1;
        own = q[j].owner;
        dat = q[j].data;
      end
      chk("core_gnt", k, 32'(cg_a[k]), 32'(ecg));
      chk("ext_gnt",  k, 32'(eg_a[k]), 32'(eeg));
      chk("mem_we",   k, 32'(we_a[k]), 32'(ewe));
      chk("mem_a",    k, a_a[k], ea);
      chk("mem_wd",   k, wd_a[k], ewd);
      chk("locked",   k, 32'(lk_a[k]), 32'(m_locked));
      chk("core_rvalid", k, 32'(crv_a[k]), 32'(hit && !own));
      chk("ext_rvalid",  k, 32'(erv_a[k]), 32'(hit && own));
      if (hit) chk("rdata", k, own ? erd_a[k] : crd_a[k], dat);
    end
    if (crv_a[2]) cnt_crv4++;
    if (erv_a[2]) cnt_erv4++;
    if (!reset) begin
      if (ecg || eeg) begin
        m_last = eeg;
        if (ewe) begin
          sh_wr[ea[7:0]]  = 1'b1;
          sh_val[ea[7:0]] = ewd;
        end else begin
          q.push_back('{cyc, eeg, sh_wr[ea[7:0]] ? sh_val[ea[7:0]] : init_val(int'(ea[7:0]))});
        end
      end
      if (!m_locked && eeg && ext_lock) m_locked = 1'b1;
      else if (m_locked && !ext_lock)   m_locked = 1'b0;
    end
    while (q.size() > 0 && q[0].issue + 4 < cyc) void'(q.pop_front());
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_lock = 0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic er, ew; logic [31:0] ea, ed; logic el;
    logic xcg, xeg, xwe; logic [31:0] xa, xwd;
    logic xlk, xcrv, xerv; logic [31:0] xrd;
  } vec_t;

  vec_t tv[12];

  initial begin
    checks = 0; errors = 0; cyc = 0; cnt_crv4 = 0; cnt_erv4 = 0;
    m_last = 1'b1; m_locked = 1'b0; rst_pulse = 1'b0;
    for (int i = 0; i < 256; i++) sh_wr[i] = 1'b0;
    idle_inputs();
    env_clr = 1'b1;

    tv[0]  = '{1,0,32'h00,0,          0,0,32'h00,0,          0, 1,0,0,32'h00,0,            0,0,0,0};
    tv[1]  = '{1,0,32'h04,0,          1,0,32'h08,0,          0, 0,1,0,32'h08,0,            0,1,0,init_val(0)};
    tv[2]  = '{1,0,32'h04,0,          1,0,32'h0C,0,          0, 1,0,0,32'h04,0,            0,0,1,init_val(8)};
    tv[3]  = '{1,0,32'h10,0,          1,0,32'h0C,0,          0, 0,1,0,32'h0C,0,            0,1,0,init_val(4)};
    tv[4]  = '{0,0,32'h00,0,          1,1,32'h20,32'hDEADBEEF,0, 0,1,1,32'h20,32'hDEADBEEF,0,0,1,init_val(12)};
    tv[5]  = '{1,0,32'h20,0,          0,0,32'h00,0,          0, 1,0,0,32'h20,0,            0,0,0,0};
    tv[6]  = '{0,0,32'h44,32'h1234,   0,0,32'h00,0,          0, 0,0,0,32'h44,32'h1234,     0,1,0,32'hDEADBEEF};
    tv[7]  = '{0,0,32'h00,0,          1,0,32'h30,0,          1, 0,1,0,32'h30,0,            0,0,0,0};
    tv[8]  = '{1,0,32'h40,0,          0,0,32'h00,0,          1, 0,0,0,32'h40,0,            1,0,1,init_val(48)};
    tv[9]  = '{1,0,32'h40,0,          1,1,32'h50,32'h55,     1, 0,1,1,32'h50,32'h55,       1,0,0,0};
    tv[10] = '{1,0,32'h40,0,          1,0,32'h54,0,          0, 0,1,0,32'h54,0,            1,0,0,0};
    tv[11] = '{1,0,32'h40,0,          1,0,32'h58,0,          0, 1,0,0,32'h40,0,            0,0,1,init_val(84)};

    // reset state
    tick();
    tick();
    env_clr = 1'b0;
    chk("rst_locked", 0, 32'(lk_a[0]), 32'd0);
    chk("rst_core_rvalid", 2, 32'(crv_a[2]), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      core_req = tv[i].cr; core_we = tv[i].cw; core_addr = tv[i].ca; core_wdata = tv[i].cd;
      ext_req = tv[i].er; ext_we = tv[i].ew; ext_addr = tv[i].ea; ext_wdata = tv[i].ed;
      ext_lock = tv[i].el;
      @(negedge clk);
      chk("tv_core_gnt", 0, 32'(cg_a[0]), 32'(tv[i].xcg));
      chk("tv_ext_gnt",  0, 32'(eg_a[0]), 32'(tv[i].xeg));
      chk("tv_mem_we",   0, 32'(we_a[0]), 32'(tv[i].xwe));
      chk("tv_mem_a",    0, a_a[0], tv[i].xa);
      chk("tv_mem_wd",   0, wd_a[0], tv[i].xwd);
      chk("tv_locked",   0, 32'(lk_a[0]), 32'(tv[i].xlk));
      chk("tv_core_rvalid", 0, 32'(crv_a[0]), 32'(tv[i].xcrv));
      chk("tv_ext_rvalid",  0, 32'(erv_a[0]), 32'(tv[i].xerv));
      if (tv[i].xcrv || tv[i].xerv)
        chk("tv_rdata", 0, tv[i].xcrv ? crd_a[0] : erd_a[0], tv[i].xrd);
      model_step();
      @(posedge clk);
      #1;
    end
    idle_inputs();
    tick();

    // lock hold and release
    ext_req = 1; ext_lock = 1; ext_addr = 32'h60;
    tick();
    ext_req = 0; core_req = 1; core_addr = 32'h70;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) ext_lock = 0;
      @(negedge clk);
      chk("lock_held", 0, 32'(lk_a[0]), 32'd1);
      chk("lock_core_blocked", 0, 32'(cg_a[0]), 32'd0);
      model_step();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("unlock_locked", 0, 32'(lk_a[0]), 32'd0);
    chk("unlock_core_gnt", 0, 32'(cg_a[0]), 32'd1);
    model_step();
    @(posedge clk);
    #1;
    idle_inputs();
    tick();

    // reset pulse while a read is in flight
    core_req = 1; core_addr = 32'h10;
    tick();
    core_req = 0;
    rst_pulse = 1'b1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    rst_pulse = 1'b0;
    core_req = 1; core_addr = 32'h14;
    @(negedge clk);
    chk("rst_mid_no_rvalid", 1, 32'(crv_a[1]), 32'd0);
    chk("rst_mid_core_gnt", 1, 32'(cg_a[1]), 32'd1);
    model_step();
    @(posedge clk);
    #1;
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // latency sweep, alternating ports
    cnt_crv4 = 0; cnt_erv4 = 0;
    for (int i = 0; i < 8; i++) begin
      core_req = (i % 2 == 0); ext_req = (i % 2 == 1);
      core_addr = 32'(i * 4); ext_addr = 32'(i * 4 + 128);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    chk("sweep_core_pulses", 2, 32'(cnt_crv4), 32'd4);
    chk("sweep_ext_pulses",  2, 32'(cnt_erv4), 32'd4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      core_req = ($urandom % 4) != 0;
      core_we = ($urandom % 4) == 0;
      core_addr = $urandom & 32'hFF;
      core_wdata = $urandom;
      ext_req = ($urandom % 2) == 0;
      ext_we = ($urandom % 4) == 0;
      ext_addr = $urandom & 32'hFF;
      ext_wdata = $urandom;
      if (($urandom % 8) == 0) ext_lock = ~ext_lock;
      if (i == 300) begin
        rst_pulse = 1'b1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      tick();
      rst_pulse = 1'b0;
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
